// File: rtl/joy_serial_pkg.sv
// Shared state encoding and sizing helpers for the serial joystick scanner.
package joy_serial_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_LOAD     = 3'd1;
  localparam state_t ST_SHIFT_LO = 3'd2;
  localparam state_t ST_SHIFT_HI = 3'd3;
  localparam state_t ST_COMMIT   = 3'd4;
  localparam state_t ST_GAP      = 3'd5;

  // Defaults for the stock two-pad, 16-bit configuration.
  localparam int TOTAL_BITS = 2 * 16;
  localparam int IDX_W      = $clog2(TOTAL_BITS);

  function automatic int idx_width(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/joy_debounce_bit.sv
// One button bit: output only follows the sample after DEBOUNCE consecutive differing frames.
module joy_debounce_bit
  import joy_serial_pkg::*;
#(
  parameter int DEBOUNCE = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sample,
  input  logic strobe,
  output logic state
);

  localparam logic [1:0] CNT_LAST = 2'(DEBOUNCE - 1);

  logic       state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (strobe) begin
      if (sample == state_q) begin
        cnt_d = 2'd0;
      end else if (cnt_q == CNT_LAST) begin
        state_d = sample;
        cnt_d   = 2'd0;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/joy_serial_multi.sv
// Multi-pad serial joystick reader: drives LOAD/CLK to a shift-register chain,
// debounces every bit per frame and commits all button words in a single clk.
module joy_serial_multi
  import joy_serial_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int BITS_PER_PLAYER = 16,
  parameter int CLK_DIV         = 32,
  parameter int GAP_TICKS       = 64,
  parameter int DEBOUNCE        = 2,
  parameter bit ACTIVE_LOW_DATA = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   enable,
  output logic                                   joy_clk,
  output logic                                   joy_load,
  input  logic                                   joy_data,
  output logic [NUM_PLAYERS*BITS_PER_PLAYER-1:0] joystick,
  output logic                                   frame_valid,
  output logic [7:0]                             frame_count,
  output logic [2:0]                             dbg_state
);

  localparam int NBITS = NUM_PLAYERS * BITS_PER_PLAYER;
  localparam int NIDX_W = idx_width(NBITS);
  localparam int DIV_W = idx_width(CLK_DIV);
  localparam int GAP_W = idx_width(GAP_TICKS);

  localparam logic [NIDX_W-1:0] LAST_IDX = NIDX_W'(NBITS - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_TICKS - 1);

  logic [DIV_W-1:0]  div_q;
  state_t            state_q, state_d;
  logic [NIDX_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [NBITS-1:0]  shreg_q, shreg_d;
  logic              joy_clk_q, joy_clk_d;
  logic              joy_load_q, joy_load_d;
  logic              frame_valid_q;
  logic [7:0]        frame_count_q;
  logic              tick;
  logic              commit;
  logic              sample;
  logic [NBITS-1:0]  frame_word;

  assign tick   = enable && (div_q == DIV_LAST);
  assign sample = joy_data ^ ACTIVE_LOW_DATA;

  always_ff @(posedge clk) begin
    if (!reset_n || !enable || tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    shreg_d = shreg_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (tick) begin
          state_d = ST_SHIFT_LO;
          idx_d   = '0;
        end
      end
      ST_SHIFT_LO: begin
        if (tick) begin
          shreg_d = {shreg_q[NBITS-2:0], sample};
          state_d = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        if (tick) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_COMMIT;
          end else begin
            idx_d   = idx_q + NIDX_W'(1);
            state_d = ST_SHIFT_LO;
          end
        end
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        gap_d   = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (tick) begin
          if (gap_q == GAP_LAST) state_d = ST_IDLE;
          else gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Losing enable abandons any partial frame; a commit in flight still lands.
    if (!enable) state_d = ST_IDLE;
    joy_clk_d  = (state_d != ST_SHIFT_LO);
    joy_load_d = (state_d != ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      gap_q         <= '0;
      shreg_q       <= '0;
      joy_clk_q     <= 1'b1;
      joy_load_q    <= 1'b1;
      frame_valid_q <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      gap_q         <= gap_d;
      shreg_q       <= shreg_d;
      joy_clk_q     <= joy_clk_d;
      joy_load_q    <= joy_load_d;
      frame_valid_q <= commit;
      frame_count_q <= frame_count_q + {7'd0, commit};
    end
  end

  // The first pad shifted out lands in the top slice; map it to player 0.
  genvar p;
  generate
    for (p = 0; p < NUM_PLAYERS; p++) begin : g_player
      assign frame_word[p*BITS_PER_PLAYER +: BITS_PER_PLAYER] =
        shreg_q[(NUM_PLAYERS-1-p)*BITS_PER_PLAYER +: BITS_PER_PLAYER];
    end
  endgenerate

  genvar b;
  generate
    for (b = 0; b < NBITS; b++) begin : g_deb
      joy_debounce_bit #(.DEBOUNCE(DEBOUNCE)) u_deb (
        .clk     (clk),
        .reset_n (reset_n),
        .sample  (frame_word[b]),
        .strobe  (commit),
        .state   (joystick[b])
      );
    end
  endgenerate

  assign joy_clk     = joy_clk_q;
  assign joy_load    = joy_load_q;
  assign frame_valid = frame_valid_q;
  assign frame_count = frame_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_joy_serial_multi.sv
// Bench for joy_serial_multi: adapter model, two debounce settings, frame-level reference model.
module tb_joy_serial_multi;

  localparam int NB = 2;
  localparam int BB = 16;
  localparam int TB = NB * BB;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic joy_data = 1'b1;

  logic          jclk1, jload1, fv1, jclk3, jload3, fv3;
  logic [TB-1:0] js1, js3;
  logic [7:0]    fc1, fc3;
  logic [2:0]    st1, st3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  joy_serial_multi #(.NUM_PLAYERS(NB), .BITS_PER_PLAYER(BB), .CLK_DIV(4), .GAP_TICKS(2),
                     .DEBOUNCE(1), .ACTIVE_LOW_DATA(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .joy_clk(jclk1), .joy_load(jload1),
    .joy_data(joy_data), .joystick(js1), .frame_valid(fv1), .frame_count(fc1), .dbg_state(st1));

  joy_serial_multi #(.NUM_PLAYERS(NB), .BITS_PER_PLAYER(BB), .CLK_DIV(4), .GAP_TICKS(2),
                     .DEBOUNCE(3), .ACTIVE_LOW_DATA(1'b1)) dut3 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .joy_clk(jclk3), .joy_load(jload3),
    .joy_data(joy_data), .joystick(js3), .frame_valid(fv3), .frame_count(fc3), .dbg_state(st3));

  // Adapter: 32 buttons (joystick layout, active high) latched on LOAD,
  // driven active-low, advancing one bit per rising serial clock.
  logic [TB-1:0] pressed = '0;
  logic [TB-1:0] latched = '0;
  int            k = 0;
  logic          prev_jclk = 1'b1;

  function automatic int stream_pos(input int n);
    return (n / BB) * BB + (BB - 1 - (n % BB));
  endfunction

  always @(negedge clk) begin
    if (!jload1) begin
      k = 0;
      latched = pressed;
    end else if (jclk1 && !prev_jclk) begin
      k = k + 1;
    end
    prev_jclk = jclk1;
    joy_data = (k < TB) ? ~latched[stream_pos(k)] : 1'b1;
  end

  // Reference model: whole-frame debounce for both settings plus frame counter.
  logic [TB-1:0] m1, m3;
  int            c1[TB];
  int            c3[TB];
  int            mfc;
  logic [TB-1:0] exp_q[$];

  task automatic deb(input int d, input logic s, inout logic o, inout int c);
    if (s == o) c = 0;
    else if (c + 1 >= d) begin o = s; c = 0; end
    else c = c + 1;
  endtask

  task automatic model_reset();
    m1 = '0; m3 = '0; mfc = 0;
    for (int i = 0; i < TB; i++) begin c1[i] = 0; c3[i] = 0; end
  endtask

  task automatic model_commit(input logic [TB-1:0] s);
    for (int i = 0; i < TB; i++) begin
      logic o; int c;
      o = m1[i]; c = c1[i]; deb(1, s[i], o, c); m1[i] = o; c1[i] = c;
      o = m3[i]; c = c3[i]; deb(3, s[i], o, c); m3[i] = o; c3[i] = c;
    end
    mfc = (mfc + 1) % 256;
    exp_q.push_back(m1);
    exp_q.push_back(m3);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called on the negedge where frame_valid is seen.
  task automatic frame_checks(input string tag);
    logic [TB-1:0] e1, e3;
    model_commit(latched);
    e1 = exp_q.pop_front();
    e3 = exp_q.pop_front();
    check({tag, "_js1"}, js1, e1);
    check({tag, "_js3"}, js3, e3);
    check({tag, "_fc"}, {24'd0, fc1}, mfc);
    check({tag, "_fv3"}, {31'd0, fv3}, 32'd1);
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    @(negedge clk);
    while (!fv1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_frame_seen"}, {31'd0, fv1}, 32'd1);
    if (fv1) frame_checks(tag);
  endtask

  initial begin
    int c, ll, lc, falls, seen, n;
    logic pj;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_joy_clk", {31'd0, jclk1}, 32'd1);
    check("rst_joy_load", {31'd0, jload1}, 32'd1);
    check("rst_js", js1, 32'd0);
    check("rst_fv", {31'd0, fv1}, 32'd0);
    check("rst_fc", {24'd0, fc1}, 32'd0);

    // 1: idle adapter, full frame timing
    reset_n = 1'b1;
    enable = 1'b1;
    n = 0;
    while (jload1 && n < 100) begin @(negedge clk); n++; end
    check("t1_load_seen", {31'd0, jload1}, 32'd0);
    c = 0; ll = 0; lc = 0; falls = 0; pj = 1'b1;
    while (!fv1 && c < 400) begin
      if (!jload1) ll++;
      if (!jclk1) lc++;
      if (pj && !jclk1) falls++;
      pj = jclk1;
      @(negedge clk);
      c++;
    end
    check("t1_fv_cycle", c, 32'd261);
    check("t1_load_clks", ll, 32'd4);
    check("t1_clk_low_clks", lc, 32'd128);
    check("t1_clk_pairs", falls, 32'd32);
    if (fv1) frame_checks("t1");
    check("t1_js_zero", js1, 32'd0);
    check("t1_fc_one", {24'd0, fc1}, 32'd1);
    @(negedge clk);
    check("t1_fv_pulse", {31'd0, fv1}, 32'd0);

    // 2: player0 bit0 and player1 bit15
    pressed = 32'h8000_0001;
    wait_frame("t2");
    check("t2_js_const", js1, 32'h8000_0001);

    // 3: DEBOUNCE=3 instance, short press rejected, 3-frame press accepted
    pressed = 32'h0000_0020;
    wait_frame("t3a1");
    check("t3_short1", {31'd0, js3[5]}, 32'd0);
    wait_frame("t3a2");
    check("t3_short2", {31'd0, js3[5]}, 32'd0);
    pressed = 32'h0;
    wait_frame("t3rel");
    check("t3_released", {31'd0, js3[5]}, 32'd0);
    pressed = 32'h0000_0020;
    wait_frame("t3b1");
    check("t3_hold1", {31'd0, js3[5]}, 32'd0);
    wait_frame("t3b2");
    check("t3_hold2", {31'd0, js3[5]}, 32'd0);
    wait_frame("t3b3");
    check("t3_hold3", {31'd0, js3[5]}, 32'd1);

    // 4: enable dropped at bit 10
    pressed = 32'h0000_1234;
    wait_frame("t4a");
    pressed = $urandom;
    n = 0;
    while (!(k == 10 && !jclk1 && jload1) && n < 2000) begin @(negedge clk); n++; end
    check("t4_bit10_reached", k, 32'd10);
    enable = 1'b0;
    @(negedge clk);
    check("t4_joy_clk", {31'd0, jclk1}, 32'd1);
    check("t4_joy_load", {31'd0, jload1}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (fv1) seen++;
      @(negedge clk);
    end
    check("t4_no_fv", seen, 32'd0);
    check("t4_js_held", js1, 32'h0000_1234);
    check("t4_fc_held", {24'd0, fc1}, mfc);
    enable = 1'b1;
    wait_frame("t4re");

    // 5: reset during SHIFT_LO
    pressed = $urandom;
    n = 0;
    while (!(k == 3 && !jclk1 && jload1) && n < 2000) begin @(negedge clk); n++; end
    check("t5_shift_lo_reached", {31'd0, jclk1}, 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    model_reset();
    check("t5_joy_clk", {31'd0, jclk1}, 32'd1);
    check("t5_joy_load", {31'd0, jload1}, 32'd1);
    check("t5_js1", js1, 32'd0);
    check("t5_js3", js3, 32'd0);
    check("t5_fc", {24'd0, fc1}, 32'd0);
    check("t5_fv", {31'd0, fv1}, 32'd0);
    reset_n = 1'b1;
    n = 0;
    while (jload1 && n < 20) begin @(negedge clk); n++; end
    check("t5_reload", {31'd0, jload1}, 32'd0);
    wait_frame("t5");

    // 6: random frames through the frame_count wrap
    for (int f = 0; f < 255; f++) begin
      pressed = $urandom;
      wait_frame("t6");
    end
    check("t6_wrap", {24'd0, fc1}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
